zoom_cmd_sequencer: RTL and testbench

Parametrised command sequencer for the image-zoom coprocessor. It accepts instructions from the HPS/pushbutton interface and drives the memory-control address generator (AGU). It rotates NUM_BUF frame buffers for read, write and display, tracks the zoom level with saturation, and raises done/error/limit flags. It adds a watchdog, address-range checking, limit rejection and generic N-buffer rotation on top of the current top-level FSM.

---
 rtl/zoom_pkg.sv | 27 ++
 rtl/zoom_cmd_sequencer_if.sv | 37 +++
 rtl/cmd_trigger.sv | 25 ++
 rtl/zoom_cmd_sequencer.sv | 166 ++++++++++++++++
 tb/tb_zoom_cmd_sequencer.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/zoom_pkg.sv
// Shared opcodes, FSM encoding and buffer-rotation helpers for the zoom command sequencer.
package zoom_pkg;

    localparam logic [2:0] NOP         = 3'b000;
    localparam logic [2:0] LOAD        = 3'b001;
    localparam logic [2:0] STORE       = 3'b010;
    localparam logic [2:0] ZOOM_IN_VP  = 3'b011;
    localparam logic [2:0] ZOOM_IN_RP  = 3'b100;
    localparam logic [2:0] ZOOM_OUT_MP = 3'b101;
    localparam logic [2:0] ZOOM_OUT_VD = 3'b110;
    localparam logic [2:0] RESET_INST  = 3'b111;

    localparam int unsigned IMG_W = 320;
    localparam int unsigned IMG_H = 240;

    typedef enum logic [2:0] {IDLE, XFER, ALGO, RST, ERR} state_t;

    // Buffer 0 holds the original image, so the destination skips it and wraps to 1.
    function automatic int unsigned next_free(input int unsigned d, input int unsigned nbuf);
        return (d == 0 || d == nbuf - 1) ? 1 : d + 1;
    endfunction

    function automatic logic is_zoom_in(input logic [2:0] op);
        return (op == ZOOM_IN_VP) || (op == ZOOM_IN_RP);
    endfunction

endpackage

// File: rtl/zoom_cmd_sequencer_if.sv
// Command/AGU/status bundle between the host side (master) and the sequencer (slave).
interface zoom_cmd_sequencer_if #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 8,
    parameter int ZOOM_W = 3,
    parameter int SEL_W  = 2
) ();
    logic              enable_n;
    logic [2:0]        instruction;
    logic [ADDR_W-1:0] mem_addr;
    logic              agu_done;
    logic [DATA_W-1:0] agu_rd_data;
    logic              agu_enable;
    logic [2:0]        agu_op;
    logic [ADDR_W-1:0] agu_addr;
    logic [ZOOM_W-1:0] zoom_level;
    logic [SEL_W-1:0]  rd_sel;
    logic [SEL_W-1:0]  wr_sel;
    logic [SEL_W-1:0]  vga_sel;
    logic [DATA_W-1:0] data_out;
    logic              flag_done;
    logic              flag_error;
    logic              flag_zoom_max;
    logic              flag_zoom_min;

    modport master (
        output enable_n, instruction, mem_addr, agu_done, agu_rd_data,
        input  agu_enable, agu_op, agu_addr, zoom_level, rd_sel, wr_sel, vga_sel,
               data_out, flag_done, flag_error, flag_zoom_max, flag_zoom_min
    );

    modport slave (
        input  enable_n, instruction, mem_addr, agu_done, agu_rd_data,
        output agu_enable, agu_op, agu_addr, zoom_level, rd_sel, wr_sel, vga_sel,
               data_out, flag_done, flag_error, flag_zoom_max, flag_zoom_min
    );
endinterface

// File: rtl/cmd_trigger.sv
// Synchronises the async active-low strobe and emits a 1-cycle start on its falling edge.
// Latency: start is high during the 2nd cycle after enable_n falls; no backpressure.
module cmd_trigger (
    input  logic clock,
    input  logic reset,
    input  logic enable_n,
    output logic start
);
    logic sync1_q, sync2_q, prev_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= enable_n;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign start = prev_q & ~sync2_q;

endmodule

// File: rtl/zoom_cmd_sequencer.sv
// Command sequencer: latches one instruction while idle, runs the AGU with a watchdog, rotates buffers.
// Latency: agu_enable rises 1 cycle after start; starts arriving while busy are dropped.
module zoom_cmd_sequencer
    import zoom_pkg::*;
#(
    parameter int unsigned ADDR_W     = 17,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned IMG_PIXELS = IMG_W * IMG_H,
    parameter int unsigned NUM_BUF    = 3,
    parameter int unsigned ZOOM_W     = 3,
    parameter int unsigned ZOOM_RESET = 4,
    parameter int unsigned ZOOM_MAX   = 7,
    parameter int unsigned ZOOM_MIN   = 1,
    parameter int unsigned TIMEOUT    = 1048575
) (
    input  logic                 clock,
    input  logic                 reset,
    zoom_cmd_sequencer_if.slave  bus
);
    localparam int SEL_W = $clog2(NUM_BUF);
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    state_t            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ZOOM_W-1:0] zoom_q, zoom_d;
    logic [SEL_W-1:0]  rd_q, rd_d, wr_q, wr_d, vga_q, vga_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              err_q, err_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic              agu_en_q, agu_en_d;
    logic              done_q, zmax_q, zmin_q;
    logic              start, in_range, at_limit, wd_expired;

    cmd_trigger u_trigger (
        .clock    (clock),
        .reset    (reset),
        .enable_n (bus.enable_n),
        .start    (start)
    );

    assign in_range   = 32'(bus.mem_addr) < IMG_PIXELS;
    assign at_limit   = is_zoom_in(bus.instruction) ? (zoom_q == ZOOM_W'(ZOOM_MAX))
                                                    : (zoom_q == ZOOM_W'(ZOOM_MIN));
    assign wd_expired = (wd_q == WD_W'(TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        zoom_d  = zoom_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        vga_d   = vga_q;
        data_d  = data_q;
        err_d   = err_q;
        wd_d    = wd_q;
        case (state_q)
            IDLE: if (start) begin
                op_d   = bus.instruction;
                addr_d = bus.mem_addr;
                err_d  = 1'b0;
                wd_d   = '0;
                case (bus.instruction)
                    LOAD, STORE: state_d = in_range ? XFER : ERR;
                    ZOOM_IN_VP, ZOOM_IN_RP, ZOOM_OUT_MP, ZOOM_OUT_VD: begin
                        if (at_limit) begin
                            state_d = ERR;
                        end else begin
                            state_d = ALGO;
                            rd_d    = vga_q;
                            wr_d    = SEL_W'(next_free(32'(vga_q), NUM_BUF));
                        end
                    end
                    RESET_INST: state_d = RST;
                    default: ;
                endcase
            end
            XFER: begin
                // agu_done takes priority over a watchdog expiry in the same cycle.
                if (bus.agu_done) begin
                    if (op_q == LOAD) data_d = bus.agu_rd_data;
                    state_d = IDLE;
                end else if (wd_expired) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            ALGO: begin
                if (bus.agu_done) begin
                    vga_d   = wr_q;
                    zoom_d  = is_zoom_in(op_q) ? zoom_q + ZOOM_W'(1) : zoom_q - ZOOM_W'(1);
                    state_d = IDLE;
                end else if (wd_expired) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            RST: begin
                zoom_d  = ZOOM_W'(ZOOM_RESET);
                vga_d   = '0;
                rd_d    = '0;
                wr_d    = SEL_W'(1);
                state_d = IDLE;
            end
            ERR: begin
                err_d   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        agu_en_d = (state_d == XFER) || (state_d == ALGO);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= IDLE;
            op_q     <= NOP;
            addr_q   <= '0;
            zoom_q   <= ZOOM_W'(ZOOM_RESET);
            rd_q     <= '0;
            wr_q     <= SEL_W'(1);
            vga_q    <= '0;
            data_q   <= '0;
            err_q    <= 1'b0;
            wd_q     <= '0;
            agu_en_q <= 1'b0;
            done_q   <= 1'b1;
            zmax_q   <= 1'b0;
            zmin_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            addr_q   <= addr_d;
            zoom_q   <= zoom_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            vga_q    <= vga_d;
            data_q   <= data_d;
            err_q    <= err_d;
            wd_q     <= wd_d;
            agu_en_q <= agu_en_d;
            done_q   <= (state_q == IDLE);
            zmax_q   <= (zoom_q == ZOOM_W'(ZOOM_MAX));
            zmin_q   <= (zoom_q == ZOOM_W'(ZOOM_MIN));
        end
    end

    assign bus.agu_enable    = agu_en_q;
    assign bus.agu_op        = op_q;
    assign bus.agu_addr      = addr_q;
    assign bus.zoom_level    = zoom_q;
    assign bus.rd_sel        = rd_q;
    assign bus.wr_sel        = wr_q;
    assign bus.vga_sel       = vga_q;
    assign bus.data_out      = data_q;
    assign bus.flag_done     = done_q;
    assign bus.flag_error    = err_q;
    assign bus.flag_zoom_max = zmax_q;
    assign bus.flag_zoom_min = zmin_q;

endmodule

// File: tb/tb_zoom_cmd_sequencer.sv
// Directed bench for zoom_cmd_sequencer with a small AGU responder (TIMEOUT shortened to 16).
module tb_zoom_cmd_sequencer;
    import zoom_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   en;
    int   exp_vga [3] = '{1, 2, 1};

    zoom_cmd_sequencer_if #(.ADDR_W(17), .DATA_W(8), .ZOOM_W(3), .SEL_W(2)) bus ();

    zoom_cmd_sequencer #(.TIMEOUT(16)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Strobes one command, answers agu_done after done_after enabled cycles (0 = never).
    task automatic do_cmd(input logic [2:0] op, input logic [16:0] addr, input int done_after,
                          input logic [7:0] rd, output int en_cyc);
        bit finished = 1'b0;
        en_cyc = 0;
        bus.instruction = op;
        bus.mem_addr    = addr;
        bus.agu_rd_data = rd;
        bus.enable_n    = 1'b0;
        for (int i = 0; i < 200 && !finished; i++) begin
            @(negedge clock);
            if (bus.agu_enable) en_cyc++;
            bus.agu_done = (done_after > 0) && bus.agu_enable && (en_cyc == done_after);
            if (i >= 6 && bus.flag_done && !bus.agu_enable) finished = 1'b1;
        end
        bus.agu_done = 1'b0;
        bus.enable_n = 1'b1;
        chk("cmd_completes", 32'(finished), 1);
        repeat (4) @(negedge clock);
    endtask

    initial begin
        bus.enable_n    = 1'b1;
        bus.instruction = NOP;
        bus.mem_addr    = '0;
        bus.agu_done    = 1'b0;
        bus.agu_rd_data = '0;
        repeat (3) @(negedge clock);

        chk("rst_agu_enable", 32'(bus.agu_enable), 0);
        chk("rst_agu_op", 32'(bus.agu_op), 0);
        chk("rst_agu_addr", 32'(bus.agu_addr), 0);
        chk("rst_zoom", 32'(bus.zoom_level), 4);
        chk("rst_rd_sel", 32'(bus.rd_sel), 0);
        chk("rst_wr_sel", 32'(bus.wr_sel), 1);
        chk("rst_vga_sel", 32'(bus.vga_sel), 0);
        chk("rst_data_out", 32'(bus.data_out), 0);
        chk("rst_flag_done", 32'(bus.flag_done), 1);
        chk("rst_flag_error", 32'(bus.flag_error), 0);
        chk("rst_flag_max", 32'(bus.flag_zoom_max), 0);
        chk("rst_flag_min", 32'(bus.flag_zoom_min), 0);
        reset = 1'b1;
        repeat (4) @(negedge clock);

        do_cmd(STORE, 17'd5, 10, 8'h00, en);
        chk("store_en_cycles", 32'(en), 10);
        chk("store_agu_op", 32'(bus.agu_op), 32'h2);
        chk("store_agu_addr", 32'(bus.agu_addr), 5);
        chk("store_flag_done", 32'(bus.flag_done), 1);
        chk("store_vga_sel", 32'(bus.vga_sel), 0);

        do_cmd(LOAD, 17'd5, 4, 8'hA5, en);
        chk("load_data_out", 32'(bus.data_out), 32'hA5);
        chk("load_flag_error", 32'(bus.flag_error), 0);
        chk("load_en_cycles", 32'(en), 4);

        for (int k = 0; k < 3; k++) begin
            do_cmd(ZOOM_IN_VP, 17'd0, 3, 8'h00, en);
            chk("zin_en_cycles", 32'(en), 3);
            chk("zin_level", 32'(bus.zoom_level), 32'(5 + k));
            chk("zin_vga_sel", 32'(bus.vga_sel), 32'(exp_vga[k]));
        end
        chk("zin_rd_sel", 32'(bus.rd_sel), 2);
        chk("zin_wr_sel", 32'(bus.wr_sel), 1);
        chk("zin_flag_max", 32'(bus.flag_zoom_max), 1);

        do_cmd(ZOOM_IN_VP, 17'd0, 3, 8'h00, en);
        chk("zmax_en_cycles", 32'(en), 0);
        chk("zmax_flag_error", 32'(bus.flag_error), 1);
        chk("zmax_level", 32'(bus.zoom_level), 7);
        chk("zmax_vga_sel", 32'(bus.vga_sel), 1);

        do_cmd(LOAD, 17'd76800, 5, 8'h3C, en);
        chk("oor_en_cycles", 32'(en), 0);
        chk("oor_flag_error", 32'(bus.flag_error), 1);
        chk("oor_data_out", 32'(bus.data_out), 32'hA5);

        do_cmd(ZOOM_OUT_VD, 17'd0, 2, 8'h00, en);
        chk("zout_level", 32'(bus.zoom_level), 6);
        chk("zout_vga_sel", 32'(bus.vga_sel), 2);
        chk("zout_flag_error", 32'(bus.flag_error), 0);
        chk("zout_flag_max", 32'(bus.flag_zoom_max), 0);

        do_cmd(ZOOM_OUT_MP, 17'd0, 0, 8'h00, en);
        chk("wdog_en_cycles", 32'(en), 16);
        chk("wdog_flag_error", 32'(bus.flag_error), 1);
        chk("wdog_level", 32'(bus.zoom_level), 6);
        chk("wdog_vga_sel", 32'(bus.vga_sel), 2);

        // Start an ALGO, fire a second strobe while busy, then reset mid-operation.
        bus.instruction = ZOOM_IN_RP;
        bus.enable_n    = 1'b0;
        repeat (5) @(negedge clock);
        chk("busy_agu_enable", 32'(bus.agu_enable), 1);
        chk("busy_flag_done", 32'(bus.flag_done), 0);
        bus.enable_n = 1'b1;
        repeat (3) @(negedge clock);
        bus.instruction = LOAD;
        bus.mem_addr    = 17'd9;
        bus.enable_n    = 1'b0;
        repeat (4) @(negedge clock);
        chk("busy_ignore_op", 32'(bus.agu_op), 32'(ZOOM_IN_RP));
        chk("busy_still_enabled", 32'(bus.agu_enable), 1);
        chk("busy_rd_sel", 32'(bus.rd_sel), 2);
        chk("busy_wr_sel", 32'(bus.wr_sel), 1);
        reset        = 1'b0;
        bus.enable_n = 1'b1;
        @(negedge clock);
        chk("midrst_agu_enable", 32'(bus.agu_enable), 0);
        chk("midrst_zoom", 32'(bus.zoom_level), 4);
        chk("midrst_vga_sel", 32'(bus.vga_sel), 0);
        chk("midrst_agu_op", 32'(bus.agu_op), 0);
        chk("midrst_flag_done", 32'(bus.flag_done), 1);
        @(negedge clock);
        reset = 1'b1;
        repeat (4) @(negedge clock);

        do_cmd(ZOOM_IN_VP, 17'd0, 2, 8'h00, en);
        chk("pre_rst_level", 32'(bus.zoom_level), 5);
        chk("pre_rst_vga_sel", 32'(bus.vga_sel), 1);

        do_cmd(RESET_INST, 17'd0, 2, 8'h00, en);
        chk("rstinst_en_cycles", 32'(en), 0);
        chk("rstinst_agu_op", 32'(bus.agu_op), 7);
        chk("rstinst_level", 32'(bus.zoom_level), 4);
        chk("rstinst_vga_sel", 32'(bus.vga_sel), 0);
        chk("rstinst_rd_sel", 32'(bus.rd_sel), 0);
        chk("rstinst_wr_sel", 32'(bus.wr_sel), 1);
        chk("rstinst_flag_error", 32'(bus.flag_error), 0);
        chk("rstinst_flag_done", 32'(bus.flag_done), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
